seq_shift_add_multiplier_ctrl: RTL and testbench
================================================

# seq_shift_add_multiplier_ctrl

Sequential shift-add multiplier controller. It multiplies two unsigned WIDTH-bit operands by reusing one WIDTH-bit ripple adder over WIDTH iterations, instead of the WIDTH-1 adder array of the combinational multiplier. The block sits in the Arithmetic group and serves as the low-area multiply unit behind a start/done handshake for the ALU and datapath sequencers. It owns the operand registers, the partial-product accumulator, the iteration counter and the control FSM.

## Interface
- WIDTH, 8, operand width; product width is 2*WIDTH; legal range 2..16.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, unsigned; captured on the accepting edge.
- b  input  WIDTH  multiplier, unsigned; captured on the accepting edge.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse; result is valid.
- out  output  2*WIDTH  product register; holds the last result.

## Operation
- State register: IDLE, RUN, DONE. The reset state is IDLE.
- **IDLE**
  - When start=1, latch a into the mcand register and b into the low half of the acc register.
  - Clear the high half of acc, clear cnt, and go to RUN.
  - When start=0, stay in IDLE.
- **RUN**, one iteration per cycle:
  - If acc[0]=1, compute {c,s} = acc[2W-1:W] + mcand, using a WIDTH-bit add with carry-out c.
  - If acc[0]=0, compute {c,s} = {1'b0, acc[2W-1:W]}.
  - Update acc <= {c, s, acc[W-1:1]}, a right shift that brings the carry into the MSB.
  - Then cnt <= cnt+1.
  - When cnt == WIDTH-1 at the edge, perform the final iteration, load out <= the new acc value, and go to DONE.
- **DONE**: done=1 for exactly this one cycle, then go unconditionally to IDLE.
- start is ignored in RUN and DONE. No queuing: a request made while busy is dropped, and the requester must re-assert it in IDLE.
- a and b are don't-care after the accepting edge, because the operands are held internally.
- Arithmetic rules:
  - Unsigned only.
  - The result is exact: out = a*b with full 2*WIDTH bits and no truncation.
  - The carry must never be lost: the maximum is (2^W-1)^2, which is 0xFE01 for W=8.
- cnt width is clog2(WIDTH)+1 bits. cnt has no wrap-around within an operation, and is cleared on each accept.
- out changes only on the RUN→DONE edge. It holds that value through IDLE and through the whole next operation until that operation finishes.
- Reset, including reset asserted mid-RUN, takes effect immediately and asynchronously:
  - state=IDLE.
  - busy=0, done=0.
  - out=0, acc=0, mcand=0, cnt=0.
  - Any partial operation is discarded, with no done pulse.

## Timing
- Reset values: busy=0, done=0, out=0.
- Edge E0 is the edge at which start=1 is sampled in IDLE. busy rises in the cycle after E0.
- Iterations occur on edges E1..EWIDTH. At edge EWIDTH, out is loaded and state goes to DONE.
- done=1 in the cycle between EWIDTH and EWIDTH+1, and busy is still 1 in that cycle.
- At EWIDTH+1 the FSM returns to IDLE and busy=0.
- Latency from the accepting edge to the done pulse is WIDTH edges (8 for the default).
- The earliest next accept is EWIDTH+2, so throughput is one product per WIDTH+2 cycles.
- done and busy are registered-state decodes with no combinational path from start.
- There is no combinational path from start, a or b to out.
- When rst_n deasserts, the first edge with rst_n=1 can already accept start.

## Test plan
- **Basic product:** reset; start with a=0x0D, b=0x0B → done pulses 8 edges after the accept, out=0x008F, busy high for 9 cycles.
- **Maximum operands:** start with a=0xFF, b=0xFF → out=0xFE01, which exercises the carry into the accumulator MSB on every iteration.
- **Zero and identity:**
  - a=0x00, b=0xA5 → out=0x0000.
  - a=0x37, b=0x01 → out=0x0037.
  - done still takes the full 8-edge latency in both cases.
- **Start while busy:** accept a=3, b=4; pulse start with a=9, b=9 at E3 and again in the DONE cycle → a single done pulse, out=0x000C, and the FSM returns to IDLE with no second operation.
- **Reset mid-operation:** accept a=0xFF, b=0x02; drop rst_n between E4 and E5 → busy=0, done=0 and out=0 immediately, with no done pulse afterwards. A new accept of a=2, b=3 then yields out=0x0006.
- **Back-to-back and hold:** accept a=0x10, b=0x10 → out=0x0100. Re-assert start at EWIDTH+2 with a=0x02, b=0x80 → out stays 0x0100 until the second done, then becomes 0x0100 again; compare against a reference model over 1000 random operand pairs.

Source files
------------

// File: rtl/seq_shift_add_multiplier_ctrl.sv
// Sequential shift-add multiplier: a single WIDTH-bit adder is reused over WIDTH cycles.
// The partial product shifts right through acc while the multiplier bits drain out of its low half.
module seq_shift_add_multiplier_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nxt;

  // Carry-out lands in the accumulator MSB, so (2^W-1)^2 never overflows.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mcand <= a;
          acc   <= {{WIDTH{1'b0}}, b};
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out   <= acc_nxt;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier_ctrl.sv
// Bench for seq_shift_add_multiplier_ctrl: directed cases with literal products plus
// randomized operations checked every cycle against a cycle-count/product model.
module tb_seq_shift_add_multiplier_ctrl;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic           busy, done;
  logic [2*W-1:0] out;

  int tests = 0;
  int fails = 0;

  seq_shift_add_multiplier_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  // Model: an accepted request keeps the unit busy for W+1 cycles; the last of them is done,
  // and the product appears in out at the start of that cycle.
  int             m_left = 0;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_out  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_out  = '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = W + 1;
        m_pend = (2*W)'(a) * (2*W)'(b);
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) m_out = m_pend;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_left != 0));
    chk("model_done", 32'(done), 32'(m_left == 1));
    chk("model_out",  32'(out),  32'(m_out));
  end

  // Issue one request from an idle cycle (just after an edge) and follow it to idle again.
  // Returns in the first idle cycle, so a following call accepts at EWIDTH+2.
  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic [2*W-1:0] exp, input bit spam, input string nm);
    int lat, nb;
    lat = -1; nb = 0;
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      a = W'($urandom); b = W'($urandom);
      if (busy) nb++;
      if (done && lat < 0) lat = k;
      if (!busy) break;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(W + 1));
    chk({nm, "_out"}, 32'(out), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int ndone;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out",  32'(out),  32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    op(8'h0D, 8'h0B, 16'h008F, 1'b0, "basic");
    op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "max");
    op(8'h00, 8'hA5, 16'h0000, 1'b0, "zero");
    op(8'h37, 8'h01, 16'h0037, 1'b0, "identity");

    // Start pulses at E3 and in the DONE cycle must both be dropped.
    a = 8'd3; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("busy_start_done_cycle", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_idle", 32'(busy), 32'd0);
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
    chk("busy_start_no_second", 32'(ndone), 32'd0);
    chk("busy_start_out", 32'(out), 32'h000C);

    // Reset between E4 and E5 discards the operation.
    a = 8'hFF; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_out",  32'(out),  32'd0);
    #7 rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
    chk("midreset_no_done", 32'(ndone), 32'd0);
    op(8'd2, 8'd3, 16'h0006, 1'b0, "after_reset");

    op(8'h10, 8'h10, 16'h0100, 1'b0, "b2b_first");
    op(8'h02, 8'h80, 16'h0100, 1'b0, "b2b_second");

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 50 == 0) begin ra = '1; rb = W'($urandom_range(0, 1) ? '1 : 0); end
      op(ra, rb, (2*W)'(ra) * (2*W)'(rb), 1'b1, "random");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
